aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
- Parametrised iterative control and state-holding block for the AES core family.
- Accepts a plaintext/key load, applies the initial AddRoundKey, then runs NUM_ROUNDS iterations through an external combinational round datapath.
- Owns the state register, round-key register, round counter, round constant and first/final flags.
- Presents the result with a one-cycle valid strobe and a ready/busy handshake. Replaces the ad-hoc counter/flag wiring of the first-generation core.

Parameters:
- DATA_W, 128: state/block width in bits.
- KEY_W, 128: key register width in bits (192/256 for extended key schedules).
- NUM_ROUNDS, 10: round iterations per block; legal range 1..15.
- RCON_INIT, 8'h01: round constant presented in round 1.

Ports:
- clk  in  1  rising-edge clock
- rst_ni  in  1  asynchronous active-low reset
- load_i  in  1  start request; accepted only when ready_o=1
- data_i  in  DATA_W  input block, sampled on accepted load
- key_i  in  KEY_W  cipher key, sampled on accepted load
- ready_o  out  1  block can accept load_i
- busy_o  out  1  round iteration in progress
- valid_o  out  1  one-cycle strobe: data_o holds a new result
- data_o  out  DATA_W  result block, held until next result
- rnd_state_o  out  DATA_W  current state to round datapath
- rnd_key_o  out  KEY_W  current round key to round datapath
- rnd_rcon_o  out  8  round constant for the current round
- rnd_first_o  out  1  current round is round 1
- rnd_final_o  out  1  current round is round NUM_ROUNDS (datapath omits MixColumns)
- rnd_state_i  in  DATA_W  next state from round datapath (combinational)
- rnd_key_i  in  KEY_W  next round key from key expansion (combinational)

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE; state, key, data_o all zero; rcon=RCON_INIT; ctr=0; valid_o=0, busy_o=0, ready_o=1, rnd_first_o=0, rnd_final_o=0.
- FSM has two states: IDLE and ROUND. ready_o = (FSM==IDLE); busy_o = (FSM==ROUND).
- IDLE with load_i=1 at edge E0:
  - state <= data_i ^ key_i[KEY_W-1 -: DATA_W]; key <= key_i.
  - ctr <= 1; rcon <= RCON_INIT; FSM -> ROUND.
- ROUND, each edge with ctr<NUM_ROUNDS:
  - state <= rnd_state_i; key <= rnd_key_i.
  - ctr <= ctr+1; rcon <= xtime(rcon).
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- ROUND, edge with ctr==NUM_ROUNDS:
  - data_o <= rnd_state_i; valid_o <= 1 for exactly one cycle.
  - FSM -> IDLE; ctr <= 0; state/key retain their last values.
- Round flags are combinational from ctr and FSM: rnd_first_o = ROUND && ctr==1; rnd_final_o = ROUND && ctr==NUM_ROUNDS. If NUM_ROUNDS=1, both are high together.
- rnd_rcon_o = rcon register. In round r it equals RCON_INIT times x^(r-1) in GF(2^8).
- Latency: load accepted at E0 -> valid_o high in the cycle after edge E(NUM_ROUNDS). busy_o is high for exactly NUM_ROUNDS cycles.
- Boundary conditions:
  - load_i while busy_o=1: ignored, no effect; no queueing.
  - load_i in the same cycle valid_o=1: accepted (FSM is IDLE), giving back-to-back throughput of one block per NUM_ROUNDS+1 cycles.
  - data_o is only updated on completion; it is not cleared on a new load.
  - Reset mid-operation: immediate return to reset values; no valid_o is issued.
- ctr width = $clog2(NUM_ROUNDS+1). ctr never exceeds NUM_ROUNDS.

Optional Feature:
- Macro AES_SEQ_ABORT_EN.
- Defined: adds input port abort_i (1 bit). abort_i=1 at an edge while in ROUND forces FSM -> IDLE, ctr <= 0, rcon <= RCON_INIT. No valid_o is issued; data_o is unchanged. abort_i outranks final-round completion on the same edge. abort_i in IDLE has no effect and does not block a simultaneous load_i.
- Undefined: no abort_i port; once started, a block always completes.

Test Plan:
- Bench stub datapath: rnd_state_i = rnd_state_o + 1, rnd_key_i = rnd_key_o ^ {KEY_W-8 zeros, rnd_rcon_o}.
- Defaults, data_i=0, key_i=0, load pulse -> busy_o high 10 cycles. valid_o pulses once 10 cycles after load edge. data_o=128'h0A. rnd_first_o only in round 1; rnd_final_o only in round 10.
- Rcon trace over the same run -> rnd_rcon_o = 01,02,04,08,10,20,40,80,1B,36 in rounds 1..10.
- Second load_i issued in round 4 with different data -> ignored; result still 128'h0A. Then a load asserted in the valid_o cycle with data_i=5 -> accepted; next data_o=128'h0F.
- rst_ni driven low asynchronously in round 6 -> all outputs at reset values before the next edge; no valid_o. A fresh load then completes normally.
- NUM_ROUNDS=1 build -> rnd_first_o and rnd_final_o high together for one cycle; data_o = (data_i^key_i)+1.
- With AES_SEQ_ABORT_EN: abort_i in round 3 -> ready_o=1 the next cycle, no valid_o, data_o retains its prior value. abort_i coincident with the round-10 edge -> no valid_o.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Iterative control and state-holding block for the AES core family. A load
// applies the initial AddRoundKey, then NUM_ROUNDS iterations are run through
// an external combinational round datapath. The result is presented with a
// one-cycle valid strobe.
//
// Optional feature macro: AES_SEQ_ABORT_EN (adds abort_i; abort returns to IDLE
// without issuing a result).
//
// Ports:
//   clk          rising-edge clock
//   rst_ni       asynchronous active-low reset
//   load_i       start request, accepted only when ready_o=1
//   abort_i      (AES_SEQ_ABORT_EN only) cancel the running block
//   data_i       input block, sampled on accepted load
//   key_i        cipher key, sampled on accepted load
//   ready_o      block can accept load_i (IDLE)
//   busy_o       round iteration in progress (ROUND)
//   valid_o      one-cycle strobe: data_o holds a new result
//   data_o       result block, held until the next result
//   rnd_state_o  current state to round datapath
//   rnd_key_o    current round key to round datapath
//   rnd_rcon_o   round constant for the current round
//   rnd_first_o  current round is round 1
//   rnd_final_o  current round is round NUM_ROUNDS
//   rnd_state_i  next state from round datapath
//   rnd_key_i    next round key from key expansion
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned KEY_W      = 128,
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              load_i,
`ifdef AES_SEQ_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] rnd_state_o,
  output logic [KEY_W-1:0]  rnd_key_o,
  output logic [7:0]        rnd_rcon_o,
  output logic              rnd_first_o,
  output logic              rnd_final_o,
  input  logic [DATA_W-1:0] rnd_state_i,
  input  logic [KEY_W-1:0]  rnd_key_i
);

  localparam int unsigned CTR_W = $clog2(NUM_ROUNDS + 1);
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NUM_ROUNDS);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ROUND = 1'b1
  } fsm_e;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  fsm_e              r_fsm;
  fsm_e              w_fsm_nxt;
  logic [DATA_W-1:0] r_state;
  logic [KEY_W-1:0]  r_key;
  logic [CTR_W-1:0]  r_ctr;
  logic [7:0]        r_rcon;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  logic              w_abort_req;
  logic              w_load_acc;
  logic              w_step;
  logic              w_done;
  logic              w_abort;
  logic              w_last;

`ifdef AES_SEQ_ABORT_EN
  assign w_abort_req = abort_i;
`else
  assign w_abort_req = 1'b0;
`endif

  assign w_last = (r_ctr == CTR_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state decode; abort outranks final-round completion.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_load_acc = 1'b0;
    w_step     = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (load_i) begin
          w_load_acc = 1'b1;
          w_fsm_nxt  = S_ROUND;
        end else begin
          w_fsm_nxt  = S_IDLE;
        end
      end
      S_ROUND: begin
        if (w_abort_req) begin
          w_abort   = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else if (w_last) begin
          w_done    = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else begin
          w_step    = 1'b1;
          w_fsm_nxt = S_ROUND;
        end
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  // State, round key, counter and round constant; state/key hold on completion.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= {DATA_W{1'b0}};
      r_key   <= {KEY_W{1'b0}};
      r_ctr   <= CTR_ZERO;
      r_rcon  <= RCON_INIT;
    end else if (w_load_acc) begin
      r_state <= data_i ^ key_i[KEY_W-1 -: DATA_W];
      r_key   <= key_i;
      r_ctr   <= CTR_ONE;
      r_rcon  <= RCON_INIT;
    end else if (w_step) begin
      r_state <= rnd_state_i;
      r_key   <= rnd_key_i;
      r_ctr   <= r_ctr + CTR_ONE;
      r_rcon  <= xtime(r_rcon);
    end else if (w_abort) begin
      r_ctr   <= CTR_ZERO;
      r_rcon  <= RCON_INIT;
    end else if (w_done) begin
      r_ctr   <= CTR_ZERO;
    end
  end

  // Result register and its one-cycle valid strobe.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= {DATA_W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= rnd_state_i;
      end
    end
  end

  assign ready_o     = (r_fsm == S_IDLE);
  assign busy_o      = (r_fsm == S_ROUND);
  assign valid_o     = r_valid;
  assign data_o      = r_data;
  assign rnd_state_o = r_state;
  assign rnd_key_o   = r_key;
  assign rnd_rcon_o  = r_rcon;
  assign rnd_first_o = (r_fsm == S_ROUND) && (r_ctr == CTR_ONE);
  assign rnd_final_o = (r_fsm == S_ROUND) && w_last;

endmodule
